// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants, FSM encodings and full-adder helper for rca_seq_ctrl
package rca_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// rtl/nibble_adder.sv - combinational 4-bit ripple-carry adder built from full adders
module nibble_adder
    import rca_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign {w_c[i+1], s[i]} = full_add(x[i], y[i], w_c[i]);
    end

    assign co = w_c[NIBBLE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - wide adder sequenced over one nibble adder; RCA_SEQ_SUB_EN adds subtract
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                         sub,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic             r_carry;
    logic [W-1:0]     r_part;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [IDX_W+1:0]    w_base;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic [W-1:0]        w_part_next;
    logic                w_last;
    logic [W-1:0]        w_opb_in;
    logic                w_cin_in;

    // Subtraction folds into the operand latch: store ~B and force the carry-in.
`ifdef RCA_SEQ_SUB_EN
    assign w_opb_in = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_opb_in = b;
    assign w_cin_in = cin;
`endif

    assign w_base = {r_idx, 2'b00};
    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

    nibble_adder u_nibble_adder (
        .x  (r_opa[w_base +: NIBBLE_W]),
        .y  (r_opb[w_base +: NIBBLE_W]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_comb begin
        w_part_next = r_part;
        w_part_next[w_base +: NIBBLE_W] = w_s;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_part  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= w_opb_in;
                        r_carry <= w_cin_in;
                        r_idx   <= '0;
                        r_part  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_part  <= w_part_next;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_sum   <= w_part_next;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - self-checking bench for rca_seq_ctrl (NIBBLES=4; RCA_SEQ_SUB_EN aware)
module tb_rca_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the whole W-bit operation in one piece of plain integer arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        longint unsigned r;
        if (s) r = longint'(x) + longint'((~y) & {W{1'b1}}) + 1;
        else   r = longint'(x) + longint'(y) + longint'(c);
        return r[W:0];
    endfunction

    // Issue one start pulse from IDLE and follow the operation to completion.
    // Returns at a falling edge with the controller back in IDLE.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, output int lat, output int busy_cnt);
        bit seen;
        lat = -1;
        busy_cnt = 0;
        seen = 0;
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                seen = 1;
            end else begin
                @(posedge clock);
                @(negedge clock);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clock);
        @(negedge clock);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t       vecs[$];
        int         lat;
        int         bc;
        logic [W:0] m;
        int         done_at[$];
        int         late_done;

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
`ifdef RCA_SEQ_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

        resetn = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum",  {16'd0, sum},  32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, bc);
            check($sformatf("vec%0d_sum", i),  {16'd0, sum},  {16'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
            check($sformatf("vec%0d_latency", i), lat, NIBBLES);
            check($sformatf("vec%0d_busy_cycles", i), bc, NIBBLES);
        end

        // Second start during ADD must be dropped.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        a = 16'hAAAA; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        late_done = 0;
        for (int k = 0; k < 14; k++) begin
            if (done) late_done++;
            if (done && late_done == 1) begin
                check("ignored_start_sum",  {16'd0, sum},  32'h5555);
                check("ignored_start_cout", {31'd0, cout}, 32'd0);
            end
            @(posedge clock);
            @(negedge clock);
        end
        check("ignored_start_done_count", late_done, 1);

        // Reset in the third ADD cycle.
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum",  {16'd0, sum},  32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        late_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) late_done++;
        end
        check("abort_no_done", late_done, 0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bc);
        check("after_abort_sum",  {16'd0, sum},  32'h0100);
        check("after_abort_cout", {31'd0, cout}, 32'd0);

        // start held high: back-to-back operations.
        a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) done_at.push_back(i);
            if (i >= 4) check($sformatf("held_sum_%0d", i), {16'd0, sum}, 32'h0406);
        end
        start = 1'b0;
        check("held_done_count", done_at.size(), 3);
        for (int i = 1; i < done_at.size(); i++)
            check($sformatf("held_period_%0d", i), done_at[i] - done_at[i-1], NIBBLES + 2);
        repeat (10) @(posedge clock);
        @(negedge clock);

        // Randomised operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 8 == 0) rb = ~ra;
            rc = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, lat, bc);
            check($sformatf("rand%0d_sum", n),  {16'd0, sum},  {16'd0, m[W-1:0]});
            check($sformatf("rand%0d_cout", n), {31'd0, cout}, {31'd0, m[W]});
            check($sformatf("rand%0d_latency", n), lat, NIBBLES);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
